cpu_core_mc: RTL and testbench
==============================

// Module: cpu_core_mc
// PURPOSE
//  Parametrised multi-cycle 16-bit-instruction CPU core; successor to the fixed 6-bit-address ROM/RAM CPU top.
//  Integrates control FSM, 16-entry register file and ALU in one block.
//  Talks to instruction and data memories over req/ready handshakes, so wait-state memories are supported.
//  Exposes separate data in/out buses instead of an inout; tristating, if needed, is done at chip top.
// PARAMETERS
//  DATA_W  16  register/ALU/data-memory width (>=8)
//  ADDR_W  6   instruction and data address width; PC wraps mod 2^ADDR_W
// PORTS
//  clk_main    in   1       single clock, all state on rising edge
//  reset       in   1       synchronous, active-high
//  imem_addr   out  ADDR_W  fetch address (= PC)
//  imem_req    out  1       fetch request
//  imem_ready  in   1       fetch accepted, imem_data valid this cycle
//  imem_data   in   16      instruction word
//  dmem_addr   out  ADDR_W  load/store address
//  dmem_req    out  1       data request
//  dmem_we     out  1       1=store, 0=load; valid while dmem_req
//  dmem_wdata  out  DATA_W  store data
//  dmem_rdata  in   DATA_W  load data, sampled when dmem_ready
//  dmem_ready  in   1       data access complete
//  halted      out  1       core stopped on HALT
// BEHAVIOUR
//  Instr: [15:12]op [11:8]DR [7:4]SA [3:0]SB/imm4. A=R[SA], B=R[SB].
//  Ops: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 NOT A; 7 SHL A,1; 8 SHR A,1 (logical);
//   9 LDI DR=zext(imm4); A ADI DR=A+zext(imm4); B LD DR=M[A]; C ST M[A]=B;
//   D BRZ if A==0 PC+=sext(imm4); E JMP PC=A[ADDR_W-1:0]; F HALT.
//  All arithmetic mod 2^DATA_W; carries dropped; addresses use A[ADDR_W-1:0].
//  FSM: FETCH -> EXEC -> (MEM for LD/ST) -> FETCH; HALT absorbing.
//   FETCH: imem_req=1, imem_addr=PC held stable until imem_ready.
//    On imem_ready edge: IR<=imem_data, PC<=PC+1, go EXEC.
//   EXEC (1 cycle): ALU/LDI/ADI write DR; BRZ taken -> PC<=PC+sext(imm4) (relative to PC+1);
//    JMP -> PC<=A; LD/ST register dmem_addr/we/wdata and go MEM; HALT -> HALT.
//   MEM: dmem_req=1, addr/we/wdata stable until dmem_ready.
//    On dmem_ready edge: LD writes DR<=dmem_rdata; go FETCH.
//   HALT: halted=1, no requests; exit only via reset.
//  Latency with zero wait states: ALU/branch 2 cycles; LD/ST 3 cycles. Each wait cycle adds 1.
//  ready while req=0 is ignored. Only one request is ever outstanding.
//  Register read sees value written in an earlier instruction; no bypass needed (single issue).
//  Reset (sync, any state incl. mid-handshake):
//   PC=0, IR=0, all registers 0, state=FETCH, halted=0, dmem_req=0, dmem_we=0,
//   dmem_addr=0, dmem_wdata=0; imem_req forced 0 while reset high.
//   An interrupted access is abandoned; memory must tolerate req dropping.
//   First fetch (addr 0) requested in the first cycle after reset falls.
//  PC wrap: fetch at 2^ADDR_W-1 -> PC=0. Branch offsets also wrap.
// CONFIGURATION
//  CPU_R0_ZERO_EN defined: R0 reads as 0 and writes to R0 are discarded.
//   LDI R0 then ADD R1,R0,R0 gives R1=0.
//  Not defined: R0 is an ordinary register.
// TESTING
//  1 Reset, ready tied 1; LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT
//    -> R3=8, halted=1 at cycle 8, imem_addr seq 0,1,2,3.
//  2 SUB R4,R2,R1 with R2=3, R1=5 -> R4=0xFFFE (DATA_W=16).
//    SHR R4 -> 0x7FFF; NOT R4 -> 0x8000.
//  3 R5=0x2A, R6=0x1234; ST [R5],R6 with dmem_ready delayed 3 cycles
//    -> dmem_req/addr=0x2A/we=1/wdata=0x1234 stable 4 cycles.
//    Then LD R7,[R5] -> R7=0x1234.
//  4 At PC=10 (R8=0): BRZ R8,-3 -> next fetch addr 8.
//    With R8=1 -> next fetch addr 11.
//    Then JMP to R9=0x3F: next fetch at 63; fetch there -> PC wraps to 0.
//  5 Assert reset for 1 cycle during MEM wait of an LD
//    -> next cycle dmem_req=0, DR unchanged (0), fetch from addr 0 resumes.
//  6 With and without CPU_R0_ZERO_EN: LDI R0,7; ADD R1,R0,R0
//    -> R1=0 (defined) / R1=14 (undefined).

Source files
------------

// File: rtl/cpu_core_mc.sv
// -----------------------------------------------------------------------------
// cpu_core_mc
//
// Multi-cycle CPU core with 16-bit instructions. It contains the control FSM,
// a 16-entry register file and the ALU. Instruction and data memory are reached
// through req/ready handshakes, so memories with wait states work unchanged.
//
// Instruction word: [15:12] op, [11:8] DR, [7:4] SA, [3:0] SB / imm4.
//   0 NOP   1 ADD   2 SUB   3 AND   4 OR    5 XOR   6 NOT A   7 SHL A
//   8 SHR A 9 LDI   A ADI   B LD    C ST    D BRZ   E JMP     F HALT
//
// Parameters:
//   DATA_W  register / ALU / data-memory width (>= 8)
//   ADDR_W  instruction and data address width; the PC wraps mod 2^ADDR_W
//
// Ports:
//   clk_main    in   single clock, every flop updates on the rising edge
//   reset       in   synchronous, active-high
//   imem_addr   out  fetch address (the PC)
//   imem_req    out  fetch request, held until imem_ready
//   imem_ready  in   fetch accepted; imem_data is valid in the same cycle
//   imem_data   in   instruction word
//   dmem_addr   out  load/store address
//   dmem_req    out  data request, held until dmem_ready
//   dmem_we     out  1 = store, 0 = load
//   dmem_wdata  out  store data
//   dmem_rdata  in   load data, sampled when dmem_ready is high
//   dmem_ready  in   data access complete
//   halted      out  core has executed HALT
//
// Configuration macro:
//   CPU_R0_ZERO_EN  when defined, R0 always reads as zero and writes to it are
//                   dropped. When undefined, R0 is an ordinary register.
// -----------------------------------------------------------------------------
module cpu_core_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk_main,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [15:0]       imem_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] dmemAddr_q, dmemAddr_d;
    logic              dmemWe_q, dmemWe_d;
    logic [DATA_W-1:0] dmemWdata_q, dmemWdata_d;
    logic [DATA_W-1:0] rf_q [16];

    logic [3:0]        opcode, dstReg, srcA, srcB;
    logic [DATA_W-1:0] opA, opB, zextImm, aluRes;
    logic [ADDR_W-1:0] branchOff;
    logic              fetchReq;
    logic              rfWe, rfCommit;
    logic [3:0]        rfWaddr;
    logic [DATA_W-1:0] rfWdata;

    assign opcode = ir_q[15:12];
    assign dstReg = ir_q[11:8];
    assign srcA   = ir_q[7:4];
    assign srcB   = ir_q[3:0];

    assign zextImm   = DATA_W'(srcB);
    // Branch offset is a signed 4-bit value widened to the PC width so the
    // addition wraps naturally modulo 2^ADDR_W.
    assign branchOff = ADDR_W'(signed'(srcB));

`ifdef CPU_R0_ZERO_EN
    assign opA      = (srcA == 4'd0) ? '0 : rf_q[srcA];
    assign opB      = (srcB == 4'd0) ? '0 : rf_q[srcB];
    assign rfCommit = rfWe && (rfWaddr != 4'd0);
`else
    assign opA      = rf_q[srcA];
    assign opB      = rf_q[srcB];
    assign rfCommit = rfWe;
`endif

    // ALU: one result per opcode; carries are dropped by the DATA_W-wide result.
    always_comb begin
        aluRes = '0;
        case (opcode)
            4'h1:    aluRes = opA + opB;
            4'h2:    aluRes = opA - opB;
            4'h3:    aluRes = opA & opB;
            4'h4:    aluRes = opA | opB;
            4'h5:    aluRes = opA ^ opB;
            4'h6:    aluRes = ~opA;
            4'h7:    aluRes = opA << 1;
            4'h8:    aluRes = opA >> 1;
            4'h9:    aluRes = zextImm;
            4'hA:    aluRes = opA + zextImm;
            default: aluRes = '0;
        endcase
    end

    // Control FSM next-state logic. A register write happens either in EXEC
    // (ALU, LDI, ADI) or at the end of MEM for a load.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        dmemAddr_d  = dmemAddr_q;
        dmemWe_d    = dmemWe_q;
        dmemWdata_d = dmemWdata_q;
        fetchReq    = 1'b0;
        rfWe        = 1'b0;
        rfWaddr     = dstReg;
        rfWdata     = aluRes;

        case (state_q)
            S_FETCH: begin
                fetchReq = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    4'h0: ;
                    4'hB: begin
                        dmemAddr_d = opA[ADDR_W-1:0];
                        dmemWe_d   = 1'b0;
                        state_d    = S_MEM;
                    end
                    4'hC: begin
                        dmemAddr_d  = opA[ADDR_W-1:0];
                        dmemWe_d    = 1'b1;
                        dmemWdata_d = opB;
                        state_d     = S_MEM;
                    end
                    // PC already points at the next instruction, so the
                    // offset is relative to PC+1 of the branch.
                    4'hD: begin
                        if (opA == '0) begin
                            pc_d = pc_q + branchOff;
                        end
                    end
                    4'hE: pc_d = opA[ADDR_W-1:0];
                    4'hF: state_d = S_HALT;
                    default: rfWe = 1'b1;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (!dmemWe_q) begin
                        rfWe    = 1'b1;
                        rfWdata = dmem_rdata;
                    end
                    state_d = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC, IR, data-port registers and register file. Reset abandons
    // any handshake in progress and restarts fetching from address 0.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            dmemAddr_q  <= '0;
            dmemWe_q    <= 1'b0;
            dmemWdata_q <= '0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            dmemAddr_q  <= dmemAddr_d;
            dmemWe_q    <= dmemWe_d;
            dmemWdata_q <= dmemWdata_d;
            if (rfCommit) begin
                rf_q[rfWaddr] <= rfWdata;
            end
        end
    end

    // The fetch request is masked combinationally so nothing is requested
    // while reset is held, even before the state register has been cleared.
    assign imem_req   = fetchReq && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_addr  = dmemAddr_q;
    assign dmem_we    = dmemWe_q;
    assign dmem_wdata = dmemWdata_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_core_mc.sv
// -----------------------------------------------------------------------------
// tb_cpu_core_mc
//
// Bench for cpu_core_mc. Small instruction and data memory models with a
// programmable number of wait states sit on the two handshake ports. Each
// program's expected fetch addresses and stores are queued up front; monitors
// pop and compare them as the core produces handshakes.
// -----------------------------------------------------------------------------
module tb_cpu_core_mc;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

`ifdef CPU_R0_ZERO_EN
    localparam logic [15:0] R0_ADD_EXP = 16'h0000;
`else
    localparam logic [15:0] R0_ADD_EXP = 16'h000E;
`endif

    logic              clk_main = 1'b0;
    logic              reset    = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ready;
    logic [15:0]       imem_data;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;
    logic              halted;

    cpu_core_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_main  (clk_main),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ready(imem_ready),
        .imem_data (imem_data),
        .dmem_addr (dmem_addr),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .halted    (halted)
    );

    always #5 clk_main = ~clk_main;

    int checks = 0;
    int passes = 0;

    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    int          imemWait = 0;
    int          dmemWait = 0;
    int          imemCnt  = 0;
    int          dmemCnt  = 0;

    logic [15:0] progQ  [$];
    logic [5:0]  fetchQ [$];
    logic [21:0] storeQ [$];
    bit          fetchCheckOn = 1'b0;

    bit          imemActive = 1'b0;
    logic [5:0]  imemHold   = '0;
    bit          dmemActive = 1'b0;
    logic [22:0] dmemHold   = '0;
    int          dmemRun    = 0;
    int          storeLen   = 0;

    // Memory models: ready rises after the configured number of wait cycles.
    assign imem_ready = imem_req && (imemCnt >= imemWait);
    assign imem_data  = imem[imem_addr];
    assign dmem_ready = dmem_req && (dmemCnt >= dmemWait);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk_main) begin
        if (!imem_req || imem_ready) imemCnt <= 0;
        else                         imemCnt <= imemCnt + 1;
        if (!dmem_req || dmem_ready) dmemCnt <= 0;
        else                         dmemCnt <= dmemCnt + 1;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Fetch monitor: address must hold while waiting, and each accepted
    // fetch must match the next expected address.
    always @(negedge clk_main) begin
        if (!reset && imem_req) begin
            if (imemActive) checkOutput("imemAddrStable", imem_addr, imemHold);
            imemHold   <= imem_addr;
            imemActive <= !imem_ready;
            if (imem_ready && fetchCheckOn) begin
                if (fetchQ.size() > 0) checkOutput("fetchAddr", imem_addr, fetchQ.pop_front());
                else                   checkOutput("unexpectedFetch", 1, 0);
            end
        end else begin
            imemActive <= 1'b0;
        end
    end

    // Data monitor: addr/we/wdata must hold while waiting; completed stores
    // are compared against the store scoreboard.
    always @(negedge clk_main) begin
        if (!reset && dmem_req) begin
            if (dmemActive) checkOutput("dmemStable", {dmem_addr, dmem_we, dmem_wdata}, dmemHold);
            dmemHold <= {dmem_addr, dmem_we, dmem_wdata};
            if (dmem_ready) begin
                dmemActive <= 1'b0;
                if (dmem_we) begin
                    storeLen <= dmemActive ? dmemRun + 1 : 1;
                    if (storeQ.size() > 0) checkOutput("storeData", {dmem_addr, dmem_wdata}, storeQ.pop_front());
                    else                   checkOutput("unexpectedStore", 1, 0);
                end
            end else begin
                dmemActive <= 1'b1;
                dmemRun    <= dmemActive ? dmemRun + 1 : 1;
            end
        end else begin
            dmemActive <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_main);
        #2;
    endtask

    // Holds reset across an edge, checks the reset state of every output,
    // loads progQ into instruction memory and releases reset.
    task automatic applyStimulus(input int iWait, input int dWait);
        reset = 1'b1;
        tick();
        @(negedge clk_main);
        checkOutput("rstImemReq",   imem_req,   0);
        checkOutput("rstImemAddr",  imem_addr,  0);
        checkOutput("rstDmemReq",   dmem_req,   0);
        checkOutput("rstDmemWe",    dmem_we,    0);
        checkOutput("rstDmemAddr",  dmem_addr,  0);
        checkOutput("rstDmemWdata", dmem_wdata, 0);
        checkOutput("rstHalted",    halted,     0);
        imemWait = iWait;
        dmemWait = dWait;
        for (int i = 0; i < 64; i++) begin
            imem[i] = (i < progQ.size()) ? progQ[i] : 16'h0000;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic runUntilHalted(input int maxCycles, output int cycles);
        cycles = 0;
        while (!halted && cycles < maxCycles) begin
            tick();
            cycles++;
        end
        checkOutput("haltReached", halted, 1);
    endtask

    task automatic finishTest();
        checkOutput("fetchQDrained", fetchQ.size(), 0);
        checkOutput("storeQDrained", storeQ.size(), 0);
        fetchQ.delete();
        storeQ.delete();
    endtask

    initial begin
        int cyc;
        int n;

        // Test 1: LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT with zero wait states.
        progQ = '{16'h9105, 16'h9203, 16'h1312, 16'hF000};
        fetchQ = '{6'd0, 6'd1, 6'd2, 6'd3};
        fetchCheckOn = 1'b1;
        applyStimulus(0, 0);
        runUntilHalted(40, cyc);
        checkOutput("haltCycle", cyc, 8);
        finishTest();

        // Test 2: ALU operations, results stored to address 0; one fetch wait.
        progQ = '{16'h9105, 16'h9203, 16'h1312, 16'hC003,
                  16'h2421, 16'hC004, 16'h8440, 16'hC004,
                  16'h6440, 16'hC004, 16'h3512, 16'hC005,
                  16'h4612, 16'hC006, 16'h5712, 16'hC007,
                  16'h7810, 16'hC008, 16'hA91F, 16'hC009,
                  16'hF000};
        storeQ = '{{6'd0, 16'h0008}, {6'd0, 16'hFFFE}, {6'd0, 16'h7FFF},
                   {6'd0, 16'h8000}, {6'd0, 16'h0001}, {6'd0, 16'h0007},
                   {6'd0, 16'h0006}, {6'd0, 16'h000A}, {6'd0, 16'h0014}};
        fetchCheckOn = 1'b0;
        applyStimulus(1, 0);
        runUntilHalted(200, cyc);
        finishTest();

        // Test 3: build R5=0x2A and R6=0x1234, store with three data wait
        // states, load back into R7 and store R7 to address 0.
        progQ = '{16'h950A, 16'h7550, 16'h7550, 16'hA552,
                  16'h9601, 16'h7660, 16'h7660, 16'h7660, 16'h7660, 16'hA662,
                  16'h7660, 16'h7660, 16'h7660, 16'h7660, 16'hA663,
                  16'h7660, 16'h7660, 16'h7660, 16'h7660, 16'hA664,
                  16'hC056, 16'hB750, 16'hC007, 16'hF000};
        storeQ = '{{6'h2A, 16'h1234}, {6'd0, 16'h1234}};
        applyStimulus(0, 3);
        runUntilHalted(300, cyc);
        checkOutput("storeReqCycles", storeLen, 4);
        finishTest();

        // Test 4: BRZ taken backwards, not taken, JMP to 63 and PC wrap to 0.
        progQ = '{16'hD0A1, 16'hF000, 16'h990F, 16'h7990, 16'h7990, 16'hA993,
                  16'h9A01, 16'hD002, 16'h9801, 16'h0000, 16'hD08D, 16'hE090};
        fetchQ = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd10, 6'd8,
                   6'd9, 6'd10, 6'd11, 6'd63, 6'd0, 6'd1};
        fetchCheckOn = 1'b1;
        applyStimulus(0, 0);
        runUntilHalted(200, cyc);
        finishTest();

        // Test 5: reset pulse during the wait phase of a load.
        progQ = '{16'hB700};
        fetchCheckOn = 1'b0;
        applyStimulus(0, 10);
        n = 0;
        while (!dmem_req && n < 20) begin
            tick();
            n++;
        end
        checkOutput("ldReachedMem", dmem_req, 1);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk_main);
        checkOutput("imemReqMaskedInReset", imem_req, 0);
        imem[0] = 16'hC007;
        imem[1] = 16'hF000;
        storeQ.push_back({6'd0, 16'h0000});
        fetchQ = '{6'd0, 6'd1};
        dmemWait = 0;
        tick();
        reset = 1'b0;
        fetchCheckOn = 1'b1;
        @(negedge clk_main);
        checkOutput("dmemReqAfterReset",  dmem_req,  0);
        checkOutput("imemReqAfterReset",  imem_req,  1);
        checkOutput("imemAddrAfterReset", imem_addr, 0);
        runUntilHalted(40, cyc);
        finishTest();

        // Test 6: LDI R0,7; ADD R1,R0,R0; LDI R2,1; ST [R2],R1.
        progQ = '{16'h9007, 16'h1100, 16'h9201, 16'hC021, 16'hF000};
        storeQ = '{{6'd1, R0_ADD_EXP}};
        fetchCheckOn = 1'b0;
        applyStimulus(0, 0);
        runUntilHalted(40, cyc);
        finishTest();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
